// File: rtl/ifft_pkg.sv
// Shared types, constants and helpers for the 8-point inverse FFT.
package ifft_pkg;
    localparam int unsigned DW   = 16;
    localparam int unsigned FRAC = 8;
    localparam int unsigned NPT  = 8;
    localparam int unsigned AW   = 3;

    typedef struct packed {
        logic signed [DW-1:0] im;
        logic signed [DW-1:0] re;
    } cplx_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Conjugate twiddles W8^-k in Q8.8.
    function automatic cplx_t tw_conj(input logic [1:0] k);
        cplx_t w;
        case (k)
            2'd0:    w = 32'h0000_0100;
            2'd1:    w = 32'h00B5_00B5;
            2'd2:    w = 32'h0100_0000;
            default: w = 32'h00B5_FF4B;
        endcase
        return w;
    endfunction

    function automatic logic [AW-1:0] bitrev3(input logic [AW-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [2*DW:0] x);
        logic signed [2*DW:0] hi;
        logic signed [2*DW:0] lo;
        hi = $signed({{(DW+2){1'b0}}, {(DW-1){1'b1}}});
        lo = $signed({{(DW+2){1'b1}}, {(DW-1){1'b0}}});
        if (x > hi)      return $signed({1'b0, {(DW-1){1'b1}}});
        else if (x < lo) return $signed({1'b1, {(DW-1){1'b0}}});
        else             return x[DW-1:0];
    endfunction
endpackage

// File: rtl/ifft_if.sv
// Streaming bin-in / sample-out bus of the inverse FFT.
interface ifft_if;
    import ifft_pkg::*;

    logic  in_valid;
    logic  in_ready;
    cplx_t in_data;
    logic  out_valid;
    logic  out_ready;
    cplx_t out_data;
    logic  out_last;
    logic  busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/ifft_bfly.sv
// Combinational scaled radix-2 butterfly: t = b*w (rounded, saturated), top=(a+t)/2, bot=(a-t)/2.
module ifft_bfly
    import ifft_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    input  cplx_t w,
    output cplx_t top,
    output cplx_t bot
);
    localparam logic signed [2*DW:0] RND =
        $signed({{(2*DW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}});

    logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [2*DW:0]   t_re_w, t_im_w;
    logic signed [DW-1:0]   t_re, t_im;
    logic signed [DW:0]     s_re, s_im, d_re, d_im;

    always_comb begin
        p_rr = $signed(b.re) * $signed(w.re);
        p_ii = $signed(b.im) * $signed(w.im);
        p_ri = $signed(b.re) * $signed(w.im);
        p_ir = $signed(b.im) * $signed(w.re);
        t_re_w = ($signed({p_rr[2*DW-1], p_rr}) - $signed({p_ii[2*DW-1], p_ii}) + RND) >>> FRAC;
        t_im_w = ($signed({p_ri[2*DW-1], p_ri}) + $signed({p_ir[2*DW-1], p_ir}) + RND) >>> FRAC;
        t_re = sat_dw(t_re_w);
        t_im = sat_dw(t_im_w);
        // 17-bit sums; dropping the LSB is a floor divide by two
        s_re = $signed({a.re[DW-1], a.re}) + $signed({t_re[DW-1], t_re});
        s_im = $signed({a.im[DW-1], a.im}) + $signed({t_im[DW-1], t_im});
        d_re = $signed({a.re[DW-1], a.re}) - $signed({t_re[DW-1], t_re});
        d_im = $signed({a.im[DW-1], a.im}) - $signed({t_im[DW-1], t_im});
        top.re = s_re[DW:1];
        top.im = s_im[DW:1];
        bot.re = d_re[DW:1];
        bot.im = d_im[DW:1];
    end
endmodule

// File: rtl/ifft_8.sv
// 8-point radix-2 DIT inverse FFT: serial load (bit-reversed), 12 in-place butterflies,
// serial natural-order output with 1/8 total scaling.
module ifft_8
    import ifft_pkg::*;
(
    input logic  clk,
    input logic  reset,
    ifft_if.slave bus
);
    state_t        state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [1:0]    stg, stg_nxt;
    logic [1:0]    bfly, bfly_nxt;
    logic          in_ready_q, busy_q;
    logic          out_valid_q, out_valid_nxt;
    logic          out_last_q, out_last_nxt;
    cplx_t         out_data_q, out_data_nxt;
    logic          ld_we_c, bf_we_c;

    cplx_t         rf [NPT];

    logic [AW-1:0] b3, span, top_addr, bot_addr;
    logic [1:0]    tw_k;
    cplx_t         tw_w, bf_top, bf_bot;

    // In-place butterfly addressing and twiddle selection for (stage, butterfly)
    always_comb begin
        b3       = {1'b0, bfly};
        span     = AW'(1) << stg;
        top_addr = ((b3 >> stg) << (stg + 2'd1)) + (b3 & (span - AW'(1)));
        bot_addr = top_addr + span;
        tw_k     = 2'((b3 & (span - AW'(1))) << (2'd2 - stg));
        tw_w     = tw_conj(tw_k);
    end

    ifft_bfly u_bfly (
        .a   (rf[top_addr]),
        .b   (rf[bot_addr]),
        .w   (tw_w),
        .top (bf_top),
        .bot (bf_bot)
    );

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        stg_nxt       = stg;
        bfly_nxt      = bfly;
        out_valid_nxt = out_valid_q;
        out_last_nxt  = out_last_q;
        out_data_nxt  = out_data_q;
        ld_we_c       = 1'b0;
        bf_we_c       = 1'b0;
        case (state)
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    ld_we_c = 1'b1;
                    idx_nxt = idx + AW'(1);
                    if (idx == AW'(NPT-1)) state_nxt = CALC;
                end
            end
            CALC: begin
                bf_we_c  = 1'b1;
                bfly_nxt = bfly + 2'd1;
                if (bfly == 2'd3) begin
                    stg_nxt = stg + 2'd1;
                    if (stg == 2'd2) begin
                        stg_nxt   = 2'd0;
                        state_nxt = OUT;
                    end
                end
            end
            OUT: begin
                if (out_valid_q && bus.out_ready && out_last_q) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    idx_nxt       = '0;
                    state_nxt     = LOAD;
                end else if (!out_valid_q || bus.out_ready) begin
                    // Output register empty or draining: present the next sample
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = rf[idx];
                    out_last_nxt  = (idx == AW'(NPT-1));
                    idx_nxt       = idx + AW'(1);
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LOAD;
            idx         <= '0;
            stg         <= '0;
            bfly        <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            stg         <= stg_nxt;
            bfly        <= bfly_nxt;
            in_ready_q  <= (state_nxt == LOAD);
            busy_q      <= (state_nxt != LOAD);
            out_valid_q <= out_valid_nxt;
            out_last_q  <= out_last_nxt;
            out_data_q  <= out_data_nxt;
        end
    end

    // Sample register file: bit-reversed load, in-place butterfly writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NPT); i++) rf[i] <= '0;
        end else if (ld_we_c) begin
            rf[bitrev3(idx)] <= bus.in_data;
        end else if (bf_we_c) begin
            rf[top_addr] <= bf_top;
            rf[bot_addr] <= bf_bot;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_ifft_8.sv
// Scoreboard bench for ifft_8: directed frames with hand-computed time samples.
module tb_ifft_8;
    import ifft_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic        tol;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifft_if bus();

    ifft_8 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          pops = 0;
    int          last_cyc = 0;
    int          first_acc_cyc = 0;
    logic [31:0] vin  [3][8];
    logic [31:0] vexp [3][8];
    logic        vtol [3][8];
    logic [31:0] mon_act;
    exp_t        mon_e;
    logic        mon_ok;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    function automatic bit near(input logic [31:0] a, input logic [31:0] e);
        int dr, di;
        dr = int'($signed(a[15:0]))  - int'($signed(e[15:0]));
        di = int'($signed(a[31:16])) - int'($signed(e[31:16]));
        return (dr >= -1) && (dr <= 1) && (di >= -1) && (di <= 1);
    endfunction

    // Monitor: compare every accepted output sample against the scoreboard head
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            mon_act = bus.out_data;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_sample actual=%08h required=none", mon_act);
            end else begin
                mon_e  = sb.pop_front();
                mon_ok = mon_e.tol ? near(mon_act, mon_e.d) : (mon_act === mon_e.d);
                mon_ok = mon_ok && (bus.out_last === mon_e.last);
                if (!mon_ok) begin
                    failures++;
                    $display("FAIL sample_x%0d actual=%08h last=%0b required=%08h last=%0b",
                             pops % 8, mon_act, bus.out_last, mon_e.d, mon_e.last);
                end
            end
            pops++;
            if (bus.out_last === 1'b1) last_cyc = cyc + 1;
        end
    end

    task automatic send_frame(input int f, input bit push);
        int n;
        if (push) begin
            for (int k = 0; k < 8; k++) begin
                exp_t e;
                e.d = vexp[f][k]; e.last = (k == 7); e.tol = vtol[f][k];
                sb.push_back(e);
            end
        end
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vin[f][k];
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 100) begin
                @(posedge clk); #1; n++;
            end
            if (n >= 100) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
            if (k == 0) first_acc_cyc = cyc;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.in_ready !== 1'b1) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check({"drain_", name}, 32'(n < 300), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        logic [31:0] held;

        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 8; k++) begin
                vin[f][k] = '0; vexp[f][k] = '0; vtol[f][k] = 1'b0;
            end
        // Frame 0: impulse
        vin[0][0] = 32'h0000_0800;
        for (int k = 0; k < 8; k++) vexp[0][k] = 32'h0000_0100;
        // Frame 1: tone at bin 1
        vin[1][1] = 32'h0000_0800;
        vexp[1][0] = 32'h0000_0100; vexp[1][1] = 32'h00B5_00B5;
        vexp[1][2] = 32'h0100_0000; vexp[1][3] = 32'h00B5_FF4B;
        vexp[1][4] = 32'h0000_FF00; vexp[1][5] = 32'hFF4B_FF4B;
        vexp[1][6] = 32'hFF00_0000; vexp[1][7] = 32'hFF4B_00B5;
        vtol[1][1] = 1'b1; vtol[1][3] = 1'b1; vtol[1][5] = 1'b1; vtol[1][7] = 1'b1;
        // Frame 2: full-scale DC
        for (int k = 0; k < 8; k++) vin[2][k] = 32'h0000_7F00;
        vexp[2][0] = 32'h0000_7F00;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  bus.out_data,       32'h0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Impulse, plus first-output latency
        send_frame(0, 1'b1);
        check("calc_busy",     32'(bus.busy),     32'd1);
        check("calc_in_ready", 32'(bus.in_ready), 32'd0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'd13);
        wait_drain("impulse");

        // Tone with in_valid held through CALC/OUT and a 5-cycle stall on x3
        send_frame(1, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        base = pops;
        n = 0;
        while (!(pops == base + 3 && bus.out_valid === 1'b1) && n < 60) begin
            check("ignore_in_valid", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1; n++;
        end
        check("reach_x3", 32'(n < 60), 32'd1);
        bus.out_ready = 1'b0;
        held = bus.out_data;
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_data",     bus.out_data,       held);
            check("stall_valid",    32'(bus.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready),  32'd0);
        end
        check("stall_no_pop", 32'(pops - base), 32'd3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain("tone");

        // Full-scale DC must not wrap
        send_frame(2, 1'b1);
        wait_drain("fullscale");

        // Reset after 5 butterflies discards the frame
        send_frame(0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy",      32'(bus.busy),      32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("postrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
        send_frame(0, 1'b1);
        wait_drain("after_reset");

        // Back-to-back frames with in_valid/out_ready held high
        send_frame(0, 1'b1);
        send_frame(1, 1'b1);
        check("b2b_first_accept", 32'(first_acc_cyc), 32'(last_cyc + 1));
        wait_drain("b2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
